// File: rtl/stp16_pkg.sv
// Shared types and constants for the STP16CPC26 chain driver.
package stp16_pkg;

  localparam int unsigned STP16_BITS = 16;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    SHIFT_LO = 2'd1,
    SHIFT_HI = 2'd2,
    LATCH    = 2'd3
  } state_e;

endpackage

// File: rtl/stp16_chain_driver_if.sv
// Frame handshake bus between the level-meter frame generator and the chain driver.
interface stp16_chain_driver_if #(
  parameter int unsigned W        = 32,
  parameter int unsigned DIM_BITS = 8
);

  logic                i_valid;
  logic                i_ready;
  logic [W-1:0]        data;
  logic [DIM_BITS-1:0] brightness;

  modport master (output i_valid, output data, output brightness, input i_ready);
  modport slave  (input i_valid, input data, input brightness, output i_ready);

endinterface

// File: rtl/stp16_pwm_dimmer.sv
// Global-brightness PWM on the active-low output enable; duty swaps only at counter wrap
// (or immediately on the very first latch) so the LEDs never see a partial period.
module stp16_pwm_dimmer #(
  parameter int unsigned DIM_BITS = 8
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                i_en,
  input  logic                i_load,
  input  logic [DIM_BITS-1:0] i_duty,
  output logic                o_noe
);

  logic [DIM_BITS-1:0] r_cnt;
  logic [DIM_BITS-1:0] r_duty;
  logic [DIM_BITS-1:0] r_pend;
  logic                w_wrap;

  assign w_wrap = (r_cnt == {DIM_BITS{1'b1}});

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cnt  <= '0;
      r_duty <= '0;
      r_pend <= '0;
      o_noe  <= 1'b1;
    end else begin
      r_cnt <= r_cnt + DIM_BITS'(1);
      if (i_load) r_pend <= i_duty;
      if (i_load && !i_en) r_duty <= i_duty;
      else if (w_wrap)     r_duty <= r_pend;
      o_noe <= !(i_en && ((r_duty == {DIM_BITS{1'b1}}) || (r_cnt < r_duty)));
    end
  end

endmodule

// File: rtl/stp16_chain_driver.sv
// Serial driver for a daisy chain of STP16CPC26 LED sinks: shift MSB-first, latch, enable.
// Optional PWM dimming on stp16_noe is built when STP16_CHAIN_DIM_EN is defined.
module stp16_chain_driver
  import stp16_pkg::*;
#(
  parameter int unsigned NUM_DEVICES = 2,
  parameter int unsigned CLK_DIV     = 2,
  parameter int unsigned LE_CYCLES   = 1,
  parameter int unsigned DIM_BITS    = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  stp16_chain_driver_if.slave  bus,
  output logic                 stp16_clk,
  output logic                 stp16_sdi,
  output logic                 stp16_le,
  output logic                 stp16_noe
);

  localparam int unsigned W       = STP16_BITS * NUM_DEVICES;
  localparam int unsigned BIT_W   = $clog2(W);
  localparam int unsigned CNT_MAX = (CLK_DIV > LE_CYCLES) ? CLK_DIV : LE_CYCLES;
  localparam int unsigned CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

  state_e           r_state, w_state_nxt;
  logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
  logic [BIT_W-1:0] r_bit, w_bit_nxt;
  logic [W-1:0]     r_shift, w_shift_nxt;
  logic             r_ready;
  logic             w_accept;
  logic             w_latch_done;

  assign bus.i_ready = r_ready;

  // Next-state: one divided shift-clock phase per SHIFT_LO/SHIFT_HI visit.
  always_comb begin
    w_state_nxt  = r_state;
    w_cnt_nxt    = r_cnt;
    w_bit_nxt    = r_bit;
    w_shift_nxt  = r_shift;
    w_accept     = 1'b0;
    w_latch_done = 1'b0;
    case (r_state)
      IDLE: begin
        if (bus.i_valid) begin
          w_accept    = 1'b1;
          w_shift_nxt = bus.data;
          w_bit_nxt   = BIT_W'(W - 1);
          w_cnt_nxt   = '0;
          w_state_nxt = SHIFT_LO;
        end
      end
      SHIFT_LO: begin
        if (r_cnt == CNT_W'(CLK_DIV - 1)) begin
          w_cnt_nxt   = '0;
          w_state_nxt = SHIFT_HI;
        end else begin
          w_cnt_nxt = r_cnt + CNT_W'(1);
        end
      end
      SHIFT_HI: begin
        if (r_cnt == CNT_W'(CLK_DIV - 1)) begin
          w_cnt_nxt = '0;
          if (r_bit == '0) begin
            w_state_nxt = LATCH;
          end else begin
            w_bit_nxt   = r_bit - BIT_W'(1);
            w_shift_nxt = {r_shift[W-2:0], 1'b0};
            w_state_nxt = SHIFT_LO;
          end
        end else begin
          w_cnt_nxt = r_cnt + CNT_W'(1);
        end
      end
      LATCH: begin
        if (r_cnt == CNT_W'(LE_CYCLES - 1)) begin
          w_cnt_nxt    = '0;
          w_latch_done = 1'b1;
          w_state_nxt  = IDLE;
        end else begin
          w_cnt_nxt = r_cnt + CNT_W'(1);
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // Pins are decoded from the next state so they change together with the state register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state   <= IDLE;
      r_cnt     <= '0;
      r_bit     <= '0;
      r_shift   <= '0;
      r_ready   <= 1'b1;
      stp16_clk <= 1'b0;
      stp16_sdi <= 1'b0;
      stp16_le  <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_cnt     <= w_cnt_nxt;
      r_bit     <= w_bit_nxt;
      r_shift   <= w_shift_nxt;
      r_ready   <= (w_state_nxt == IDLE);
      stp16_clk <= (w_state_nxt == SHIFT_HI);
      stp16_sdi <= w_shift_nxt[W-1];
      stp16_le  <= (w_state_nxt == LATCH);
    end
  end

`ifdef STP16_CHAIN_DIM_EN
  logic [DIM_BITS-1:0] r_bright_q;
  logic                r_first_latch;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_bright_q    <= '0;
      r_first_latch <= 1'b0;
    end else begin
      if (w_accept)     r_bright_q    <= bus.brightness;
      if (w_latch_done) r_first_latch <= 1'b1;
    end
  end

  stp16_pwm_dimmer #(.DIM_BITS(DIM_BITS)) u_dimmer (
    .clk    (clk),
    .reset  (reset),
    .i_en   (r_first_latch),
    .i_load (w_latch_done),
    .i_duty (r_bright_q),
    .o_noe  (stp16_noe)
  );
`else
  logic w_unused_brightness;
  assign w_unused_brightness = ^{bus.brightness, w_accept};

  // Outputs stay blanked until the chain holds a complete, latched frame.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)             stp16_noe <= 1'b1;
    else if (w_latch_done) stp16_noe <= 1'b0;
  end
`endif

endmodule

// File: tb/tb_stp16_chain_driver.sv
// Self-checking bench: default 2-device chain and a 3-device CLK_DIV=1/LE_CYCLES=3 chain.
module tb_stp16_chain_driver;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_a, rst_b;
  logic a_sclk, a_sdi, a_le, a_noe;
  logic b_sclk, b_sdi, b_le, b_noe;

  stp16_chain_driver_if #(.W(32), .DIM_BITS(8)) if_a ();
  stp16_chain_driver_if #(.W(48), .DIM_BITS(8)) if_b ();

  stp16_chain_driver dut_a (
    .clk(clk), .reset(rst_a), .bus(if_a),
    .stp16_clk(a_sclk), .stp16_sdi(a_sdi), .stp16_le(a_le), .stp16_noe(a_noe)
  );

  stp16_chain_driver #(.NUM_DEVICES(3), .CLK_DIV(1), .LE_CYCLES(3)) dut_b (
    .clk(clk), .reset(rst_b), .bus(if_b),
    .stp16_clk(b_sclk), .stp16_sdi(b_sdi), .stp16_le(b_le), .stp16_noe(b_noe)
  );

`ifdef STP16_CHAIN_DIM_EN
  localparam logic NOE_AFTER_DARK_FRAME = 1'b1;
`else
  localparam logic NOE_AFTER_DARK_FRAME = 1'b0;
`endif

  int n_vec = 0;
  int n_fail = 0;
  int cyc = 0;
  bit q_a[$];
  bit q_b[$];
  int a_rise, a_hi, a_le_pulses, a_le_cyc, a_busy, a_glitch;
  int b_rise, b_hi, b_le_pulses, b_le_cyc, b_busy, b_glitch;
  logic a_sclk_p, a_le_p, a_sdi_p, b_sclk_p, b_le_p, b_sdi_p;

  task automatic clear_counts();
    a_rise = 0; a_hi = 0; a_le_pulses = 0; a_le_cyc = 0; a_busy = 0; a_glitch = 0;
    b_rise = 0; b_hi = 0; b_le_pulses = 0; b_le_cyc = 0; b_busy = 0; b_glitch = 0;
  endtask

  // Advance to the next falling clk edge and check each shifted bit against the scoreboard.
  task automatic step();
    bit e;
    @(negedge clk);
    cyc++;
    if (a_sclk === 1'b1 && a_sclk_p === 1'b0) begin
      a_rise++;
      n_vec++;
      if (q_a.size() == 0) begin
        n_fail++;
        $display("FAIL sdi_a: unexpected shift edge, got sdi=%0b, expected no edge", a_sdi);
      end else begin
        e = q_a.pop_front();
        if (a_sdi !== e) begin
          n_fail++;
          $display("FAIL sdi_a: edge %0d got %0b expected %0b", a_rise, a_sdi, e);
        end
      end
    end
    if (b_sclk === 1'b1 && b_sclk_p === 1'b0) begin
      b_rise++;
      n_vec++;
      if (q_b.size() == 0) begin
        n_fail++;
        $display("FAIL sdi_b: unexpected shift edge, got sdi=%0b, expected no edge", b_sdi);
      end else begin
        e = q_b.pop_front();
        if (b_sdi !== e) begin
          n_fail++;
          $display("FAIL sdi_b: edge %0d got %0b expected %0b", b_rise, b_sdi, e);
        end
      end
    end
    if (a_sclk === 1'b1) a_hi++;
    if (b_sclk === 1'b1) b_hi++;
    if (a_sclk === 1'b1 && a_sclk_p === 1'b1 && a_sdi !== a_sdi_p) a_glitch++;
    if (b_sclk === 1'b1 && b_sclk_p === 1'b1 && b_sdi !== b_sdi_p) b_glitch++;
    if (a_le === 1'b1 && a_le_p !== 1'b1) a_le_pulses++;
    if (b_le === 1'b1 && b_le_p !== 1'b1) b_le_pulses++;
    if (a_le === 1'b1) a_le_cyc++;
    if (b_le === 1'b1) b_le_cyc++;
    if (if_a.i_ready !== 1'b1) a_busy++;
    if (if_b.i_ready !== 1'b1) b_busy++;
    a_sclk_p = a_sclk; a_le_p = a_le; a_sdi_p = a_sdi;
    b_sclk_p = b_sclk; b_le_p = b_le; b_sdi_p = b_sdi;
  endtask

  // Offer a frame on A; returns the cycle index of the negedge preceding the accept edge.
  task automatic send_a(input logic [31:0] d, input logic [7:0] br, input bit keep, output int acc);
    int guard;
    if_a.i_valid = 1'b1; if_a.data = d; if_a.brightness = br;
    guard = 0;
    while (if_a.i_ready !== 1'b1 && guard < 1000) begin step(); guard++; end
    n_vec++;
    if (guard >= 1000) begin
      n_fail++;
      $display("FAIL accept_a: timeout, i_ready=%0b expected 1", if_a.i_ready);
    end
    for (int i = 31; i >= 0; i--) q_a.push_back(d[i]);
    acc = cyc;
    step();
    if (!keep) if_a.i_valid = 1'b0;
    if_a.data = ~d; if_a.brightness = ~br;
  endtask

  task automatic send_b(input logic [47:0] d);
    int guard;
    if_b.i_valid = 1'b1; if_b.data = d; if_b.brightness = 8'h00;
    guard = 0;
    while (if_b.i_ready !== 1'b1 && guard < 1000) begin step(); guard++; end
    n_vec++;
    if (guard >= 1000) begin
      n_fail++;
      $display("FAIL accept_b: timeout, i_ready=%0b expected 1", if_b.i_ready);
    end
    for (int i = 47; i >= 0; i--) q_b.push_back(d[i]);
    step();
    if_b.i_valid = 1'b0; if_b.data = ~d;
  endtask

  task automatic wait_idle(input bit on_b);
    int guard;
    guard = 0;
    while (((on_b ? if_b.i_ready : if_a.i_ready) !== 1'b1) && guard < 2000) begin
      step(); guard++;
    end
    n_vec++;
    if (guard >= 2000) begin
      n_fail++;
      $display("FAIL idle_%s: timeout waiting for i_ready, expected 1", on_b ? "b" : "a");
    end
    repeat (3) step();
  endtask

  task automatic test_reset();
    if_a.i_valid = 1'b0; if_a.data = '0; if_a.brightness = '0;
    if_b.i_valid = 1'b0; if_b.data = '0; if_b.brightness = '0;
    rst_a = 1'b1; rst_b = 1'b1;
    repeat (2) step();
    rst_a = 1'b0; rst_b = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step();
      n_vec++;
      if ({if_a.i_ready, a_noe, a_sclk, a_sdi, a_le} !== 5'b11000) begin
        n_fail++;
        $display("FAIL reset_a: rdy/noe/clk/sdi/le=%b expected 11000",
                 {if_a.i_ready, a_noe, a_sclk, a_sdi, a_le});
      end
      n_vec++;
      if ({if_b.i_ready, b_noe, b_sclk, b_sdi, b_le} !== 5'b11000) begin
        n_fail++;
        $display("FAIL reset_b: rdy/noe/clk/sdi/le=%b expected 11000",
                 {if_b.i_ready, b_noe, b_sclk, b_sdi, b_le});
      end
    end
  endtask

  task automatic check_frame_a(input string nm, input int frames);
    n_vec++;
    if (a_rise !== 32 * frames) begin n_fail++; $display("FAIL %s rises: got %0d expected %0d", nm, a_rise, 32 * frames); end
    n_vec++;
    if (a_hi !== 64 * frames) begin n_fail++; $display("FAIL %s clk_high: got %0d expected %0d", nm, a_hi, 64 * frames); end
    n_vec++;
    if (a_le_pulses !== frames || a_le_cyc !== frames) begin
      n_fail++; $display("FAIL %s le: pulses %0d cycles %0d expected %0d/%0d", nm, a_le_pulses, a_le_cyc, frames, frames);
    end
    n_vec++;
    if (a_busy !== 129 * frames) begin n_fail++; $display("FAIL %s busy: got %0d expected %0d", nm, a_busy, 129 * frames); end
    n_vec++;
    if (q_a.size() !== 0 || a_glitch !== 0) begin
      n_fail++; $display("FAIL %s leftover: bits %0d sdi_changes_while_high %0d expected 0/0", nm, q_a.size(), a_glitch);
    end
    n_vec++;
    if (a_noe !== NOE_AFTER_DARK_FRAME) begin
      n_fail++; $display("FAIL %s noe: got %0b expected %0b", nm, a_noe, NOE_AFTER_DARK_FRAME);
    end
  endtask

  task automatic test_single_frame();
    int acc;
    clear_counts();
    send_a(32'h12345678, 8'h00, 1'b0, acc);
    wait_idle(1'b0);
    check_frame_a("single", 1);
  endtask

  task automatic test_back_to_back();
    int acc1, acc2;
    clear_counts();
    send_a(32'h12345678, 8'h00, 1'b1, acc1);
    send_a(32'h55555555, 8'h00, 1'b0, acc2);
    wait_idle(1'b0);
    n_vec++;
    if (acc2 - acc1 !== 130) begin
      n_fail++; $display("FAIL b2b_gap: accept spacing %0d expected 130", acc2 - acc1);
    end
    check_frame_a("b2b", 2);
  endtask

  task automatic test_three_devices();
    clear_counts();
    send_b(48'hC3A5_0F96_1E7B);
    wait_idle(1'b1);
    n_vec++;
    if (b_rise !== 48 || b_hi !== 48) begin
      n_fail++; $display("FAIL cfg_b clk: rises %0d high %0d expected 48/48", b_rise, b_hi);
    end
    n_vec++;
    if (b_le_pulses !== 1 || b_le_cyc !== 3) begin
      n_fail++; $display("FAIL cfg_b le: pulses %0d cycles %0d expected 1/3", b_le_pulses, b_le_cyc);
    end
    n_vec++;
    if (b_busy !== 99) begin n_fail++; $display("FAIL cfg_b busy: got %0d expected 99", b_busy); end
    n_vec++;
    if (q_b.size() !== 0 || b_glitch !== 0) begin
      n_fail++; $display("FAIL cfg_b leftover: bits %0d sdi_changes_while_high %0d expected 0/0", q_b.size(), b_glitch);
    end
  endtask

  task automatic test_reset_mid_frame();
    int acc, guard;
    clear_counts();
    send_a(32'h12345678, 8'h00, 1'b0, acc);
    guard = 0;
    while (a_rise < 10 && guard < 200) begin step(); guard++; end
    rst_a = 1'b1;
    #1;
    n_vec++;
    if ({if_a.i_ready, a_noe, a_sclk, a_sdi, a_le} !== 5'b11000 || a_rise !== 10) begin
      n_fail++;
      $display("FAIL midrst: rdy/noe/clk/sdi/le=%b at edge %0d expected 11000 at 10",
               {if_a.i_ready, a_noe, a_sclk, a_sdi, a_le}, a_rise);
    end
    q_a.delete();
    repeat (2) step();
    rst_a = 1'b0;
    step();
    clear_counts();
    send_a(32'hA5A5A5A5, 8'h00, 1'b0, acc);
    n_vec++;
    if (a_noe !== 1'b1) begin n_fail++; $display("FAIL midrst noe_before_latch: got %0b expected 1", a_noe); end
    wait_idle(1'b0);
    check_frame_a("after_rst", 1);
  endtask

  // Count noe-low cycles over one full 256-cycle PWM period per brightness setting.
  task automatic test_brightness();
    logic [7:0] br[3] = '{8'd64, 8'd255, 8'd0};
    int exp_low, low, acc;
    for (int k = 0; k < 3; k++) begin
`ifdef STP16_CHAIN_DIM_EN
      exp_low = (br[k] == 8'd255) ? 256 : int'(br[k]);
`else
      exp_low = 256;
`endif
      send_a(32'h0F0F_F0F0, br[k], 1'b0, acc);
      wait_idle(1'b0);
      q_a.delete();
      repeat (300) step();
      low = 0;
      for (int i = 0; i < 256; i++) begin
        step();
        if (a_noe === 1'b0) low++;
      end
      n_vec++;
      if (low !== exp_low) begin
        n_fail++; $display("FAIL bright_%0d: noe low %0d of 256 expected %0d", br[k], low, exp_low);
      end
    end
  endtask

  initial begin
    clear_counts();
    a_sclk_p = 1'b0; a_le_p = 1'b0; a_sdi_p = 1'b0;
    b_sclk_p = 1'b0; b_le_p = 1'b0; b_sdi_p = 1'b0;
    test_reset();
    test_single_frame();
    test_back_to_back();
    test_three_devices();
    test_reset_mid_frame();
    test_brightness();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
